// File: rtl/lfsr.sv
// ---------------------------------------------------------------------------
// lfsr -- 16-bit Fibonacci linear-feedback shift register.
//
// Produces one pseudo-random bit per enabled clock cycle. Reset loads a
// fixed non-zero seed. The taps give a maximal-length sequence that visits
// every non-zero 16-bit state once per 65535 steps.
//
// Ports
//   clk        in   1   rising-edge clock for all state
//   rst        in   1   synchronous, active-high reset (has priority over en)
//   en         in   1   step enable, sampled on each rising clk edge
//   rand_bit   out  1   registered; the LSB shifted out on the latest step
//   shift_reg  out  16  registered; the current LFSR state
// ---------------------------------------------------------------------------
module lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rand_bit,
    output logic [15:0] shift_reg
);

    localparam logic [15:0] SEED = 16'hECEB;

    logic [15:0] state_q;
    logic [15:0] state_d;
    logic        bit_q;
    logic        bit_d;

    // Taps at bits 0, 2, 3 and 5 of the current state; the XOR result is
    // shifted in at the MSB so the polynomial stays maximal-length.
    function automatic logic feedback(input logic [15:0] s);
        return s[0] ^ s[2] ^ s[3] ^ s[5];
    endfunction

    // Next state: a step shifts right and captures the outgoing LSB;
    // otherwise both registers hold.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        if (en) begin
            state_d = {feedback(state_q), state_q[15:1]};
            bit_d   = state_q[0];
        end
    end

    // ---- register stage: state and output bit ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
            bit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
        end
    end

    assign shift_reg = state_q;
    assign rand_bit  = bit_q;

endmodule

// File: tb/tb_lfsr.sv
// ---------------------------------------------------------------------------
// tb_lfsr -- self-checking bench for lfsr.
//
// The reference model treats the LFSR as polynomial arithmetic: the next
// state is the state shifted right by one with the parity of (state & taps)
// placed in the MSB. Directed steps run in one initial block.
// ---------------------------------------------------------------------------
module tb_lfsr;

    logic        clk;
    logic        rst;
    logic        en;
    logic        rand_bit;
    logic [15:0] shift_reg;

    int total;
    int bad;

    // Reference model state
    logic [15:0] m_state;
    logic        m_bit;

    localparam logic [15:0] SEED     = 16'hECEB;
    localparam logic [15:0] TAP_MASK = 16'h002D;  // bits 0,2,3,5

    lfsr dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rand_bit  (rand_bit),
        .shift_reg (shift_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic parity;
        parity = ^(s & TAP_MASK);
        return (s >> 1) | ({15'd0, parity} << 15);
    endfunction

    task automatic model_step();
        m_bit   = m_state[0];
        m_state = model_next(m_state);
    endtask

    task automatic model_reset();
        m_state = SEED;
        m_bit   = 1'b0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit
    // after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk(tag, {rand_bit, shift_reg}, {m_bit, m_state});
    endtask

    initial begin
        int gap;
        bit hit_seed;
        bit hit_zero;
        bit diverged;
        logic [16:0] first_div_obs;
        logic [16:0] first_div_exp;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        en    = 1'b0;
        model_reset();

        // ---- reset for two cycles, then idle ----
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("reset_edge1", {rand_bit, shift_reg}, {1'b0, 16'hECEB});
        tick();
        chk("reset_edge2", {rand_bit, shift_reg}, {1'b0, 16'hECEB});
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_after_reset", {rand_bit, shift_reg}, {1'b0, 16'hECEB});
        end

        // ---- three single-cycle steps from the seed ----
        en = 1'b1; tick(); en = 1'b0;
        chk("step1", {rand_bit, shift_reg}, {1'b1, 16'hF675});
        tick();
        en = 1'b1; tick(); en = 1'b0;
        chk("step2", {rand_bit, shift_reg}, {1'b1, 16'hFB3A});
        tick();
        en = 1'b1; tick(); en = 1'b0;
        chk("step3", {rand_bit, shift_reg}, {1'b0, 16'h7D9D});
        model_step(); model_step(); model_step();

        // ---- random idle gaps between single steps ----
        for (int n = 0; n < 300; n++) begin
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk_model("gap_hold");
            end
            en = 1'b1; tick(); en = 1'b0;
            model_step();
            chk_model("random_step");
        end

        // ---- reset has priority over en ----
        rst = 1'b1;
        en  = 1'b1;
        tick();
        model_reset();
        chk("reset_priority", {rand_bit, shift_reg}, {1'b0, 16'hECEB});
        rst = 1'b0;

        // ---- back-to-back steps, continuing through the full period ----
        tick();
        chk("b2b_1", {1'b0, shift_reg}, {1'b0, 16'hF675});
        tick();
        chk("b2b_2", {1'b0, shift_reg}, {1'b0, 16'hFB3A});
        tick();
        chk("b2b_3", {1'b0, shift_reg}, {1'b0, 16'h7D9D});
        model_step(); model_step(); model_step();

        hit_seed      = 1'b0;
        hit_zero      = 1'b0;
        diverged      = 1'b0;
        first_div_obs = '0;
        first_div_exp = '0;
        for (int n = 4; n <= 65535; n++) begin
            tick();
            model_step();
            if (!diverged && ({rand_bit, shift_reg} !== {m_bit, m_state})) begin
                diverged      = 1'b1;
                first_div_obs = {rand_bit, shift_reg};
                first_div_exp = {m_bit, m_state};
            end
            if (n < 65535 && shift_reg === SEED) hit_seed = 1'b1;
            if (shift_reg === 16'h0000) hit_zero = 1'b1;
        end
        en = 1'b0;
        chk("period_track_model", first_div_obs, first_div_exp);
        chk("period_returns_seed", {1'b0, shift_reg}, {1'b0, SEED});
        chk("period_no_early_seed", {16'd0, hit_seed}, 17'd0);
        chk("period_no_zero", {16'd0, hit_zero}, 17'd0);

        // ---- hold after the full period ----
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_model("final_hold");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
